// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Supplies a next-fetch prediction and resolves ID-stage outcomes into mispredict redirects.
module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] FetchPC,
  output logic        PredTaken,
  output logic [31:0] PredNextPC,
  input  logic        ResValid,
  input  logic [31:0] ResPC,
  input  logic [5:0]  ResControl,
  input  logic        ResTaken,
  input  logic [31:0] ResTarget,
  input  logic        ResPredTaken,
  input  logic [31:0] ResPredNextPC,
  output logic        Mispredict,
  output logic [31:0] CorrectPC,
  output logic [15:0] BranchCount,
  output logic [15:0] MissCount
);

  localparam int TAG_W = 30 - IDX_W;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [15:0]      r_branchCount;
  logic [15:0]      r_missCount;

  logic [IDX_W-1:0] w_fetchIdx;
  logic [TAG_W-1:0] w_fetchTag;
  logic             w_fetchHit;
  logic [IDX_W-1:0] w_resIdx;
  logic [TAG_W-1:0] w_resTag;
  logic             w_resHit;
  logic             w_isBranch;
  logic             w_isJump;
  logic             w_resolve;
  logic             w_other;
  logic [31:0]      w_resPcPlus4;

  assign w_fetchIdx = FetchPC[IDX_W+1:2];
  assign w_fetchTag = FetchPC[31:IDX_W+2];
  assign w_fetchHit = r_valid[w_fetchIdx] && (r_tag[w_fetchIdx] == w_fetchTag);

  assign PredTaken  = w_fetchHit && r_ctr[w_fetchIdx][1];
  assign PredNextPC = PredTaken ? r_target[w_fetchIdx] : FetchPC + 32'd4;

  assign w_resIdx     = ResPC[IDX_W+1:2];
  assign w_resTag     = ResPC[31:IDX_W+2];
  assign w_resHit     = r_valid[w_resIdx] && (r_tag[w_resIdx] == w_resTag);
  assign w_isBranch   = (ResControl == 6'd18) || (ResControl == 6'd19);
  assign w_isJump     = (ResControl == 6'd23) || (ResControl == 6'd24) || (ResControl == 6'd25);
  assign w_resolve    = ResValid && (w_isBranch || w_isJump);
  assign w_other      = ResValid && !(w_isBranch || w_isJump);
  assign w_resPcPlus4 = ResPC + 32'd4;

  // A non-control instruction that was predicted taken is a BTB alias: fall through to PC+4.
  assign Mispredict = w_resolve ? ((ResTaken != ResPredTaken) ||
                                   (ResTaken && ResPredTaken && (ResPredNextPC != ResTarget)))
                                : (w_other && ResPredTaken);
  assign CorrectPC  = (w_resolve && ResTaken) ? ResTarget : w_resPcPlus4;

  assign BranchCount = r_branchCount;
  assign MissCount   = r_missCount;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'd0;
      end
      r_branchCount <= 16'd0;
      r_missCount   <= 16'd0;
    end else begin
      if (w_resolve) begin
        if (w_resHit) begin
          if (w_isJump)
            r_ctr[w_resIdx] <= 2'd3;
          else if (ResTaken)
            r_ctr[w_resIdx] <= (r_ctr[w_resIdx] == 2'd3) ? 2'd3 : r_ctr[w_resIdx] + 2'd1;
          else
            r_ctr[w_resIdx] <= (r_ctr[w_resIdx] == 2'd0) ? 2'd0 : r_ctr[w_resIdx] - 2'd1;
          if (ResTaken)
            r_target[w_resIdx] <= ResTarget;
        end else if (ResTaken) begin
          r_valid[w_resIdx]  <= 1'b1;
          r_tag[w_resIdx]    <= w_resTag;
          r_target[w_resIdx] <= ResTarget;
          r_ctr[w_resIdx]    <= w_isJump ? 2'd3 : 2'd2;
        end
        if (r_branchCount != 16'hFFFF)
          r_branchCount <= r_branchCount + 16'd1;
      end else if (w_other && ResPredTaken && w_resHit) begin
        r_valid[w_resIdx] <= 1'b0;
      end
      if (Mispredict && (r_missCount != 16'hFFFF))
        r_missCount <= r_missCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: directed literal checks, randomized traffic against a table model, counter saturation.
module tb_branch_target_predictor;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] FetchPC;
  logic        PredTaken;
  logic [31:0] PredNextPC;
  logic        ResValid;
  logic [31:0] ResPC;
  logic [5:0]  ResControl;
  logic        ResTaken;
  logic [31:0] ResTarget;
  logic        ResPredTaken;
  logic [31:0] ResPredNextPC;
  logic        Mispredict;
  logic [31:0] CorrectPC;
  logic [15:0] BranchCount;
  logic [15:0] MissCount;

  int nCompared = 0;
  int nMismatched = 0;
  bit checkEn = 0;

  // Reference model: one record per index, full-address tag, integer counter.
  bit        mValid [16];
  bit [25:0] mTag   [16];
  bit [31:0] mTgt   [16];
  int        mCtr   [16];
  int        mBC;
  int        mMC;

  branch_target_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .FetchPC(FetchPC), .PredTaken(PredTaken), .PredNextPC(PredNextPC),
    .ResValid(ResValid), .ResPC(ResPC), .ResControl(ResControl), .ResTaken(ResTaken),
    .ResTarget(ResTarget), .ResPredTaken(ResPredTaken), .ResPredNextPC(ResPredNextPC),
    .Mispredict(Mispredict), .CorrectPC(CorrectPC), .BranchCount(BranchCount), .MissCount(MissCount)
  );

  always #5 Clk = ~Clk;

  function automatic bit isCtl(logic [5:0] c);
    return (c == 18) || (c == 19) || (c == 23) || (c == 24) || (c == 25);
  endfunction

  function automatic bit isJmp(logic [5:0] c);
    return (c == 23) || (c == 24) || (c == 25);
  endfunction

  function automatic bit mHit(logic [31:0] pc);
    int idx = int'(pc[5:2]);
    return mValid[idx] && (mTag[idx] == pc[31:6]);
  endfunction

  function automatic bit expPredTaken(logic [31:0] pc);
    return mHit(pc) && (mCtr[int'(pc[5:2])] >= 2);
  endfunction

  function automatic logic [31:0] expPredNext(logic [31:0] pc);
    return expPredTaken(pc) ? mTgt[int'(pc[5:2])] : pc + 32'd4;
  endfunction

  function automatic bit expMisp();
    if (!ResValid) return 0;
    if (isCtl(ResControl))
      return (ResTaken != ResPredTaken) || (ResTaken && ResPredTaken && ResPredNextPC != ResTarget);
    return ResPredTaken;
  endfunction

  function automatic logic [31:0] expCorrect();
    return (ResValid && isCtl(ResControl) && ResTaken) ? ResTarget : ResPC + 32'd4;
  endfunction

  task automatic modelUpdate();
    int idx;
    bit hit;
    bit mis;
    if (!Rst) begin
      for (int i = 0; i < 16; i++) begin
        mValid[i] = 0; mTag[i] = 0; mTgt[i] = 0; mCtr[i] = 0;
      end
      mBC = 0; mMC = 0;
      return;
    end
    idx = int'(ResPC[5:2]);
    hit = mHit(ResPC);
    mis = expMisp();
    if (ResValid && isCtl(ResControl)) begin
      if (hit) begin
        if (isJmp(ResControl)) mCtr[idx] = 3;
        else if (ResTaken)     mCtr[idx] = (mCtr[idx] + 1 > 3) ? 3 : mCtr[idx] + 1;
        else                   mCtr[idx] = (mCtr[idx] - 1 < 0) ? 0 : mCtr[idx] - 1;
        if (ResTaken) mTgt[idx] = ResTarget;
      end else if (ResTaken) begin
        mValid[idx] = 1; mTag[idx] = ResPC[31:6]; mTgt[idx] = ResTarget;
        mCtr[idx] = isJmp(ResControl) ? 3 : 2;
      end
      if (mBC < 65535) mBC++;
    end else if (ResValid && ResPredTaken && hit) begin
      mValid[idx] = 0;
    end
    if (mis && mMC < 65535) mMC++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs against the model every cycle once reset has been applied.
  always @(negedge Clk) begin
    if (checkEn) begin
      checkOutput("PredTaken", {31'd0, PredTaken}, {31'd0, expPredTaken(FetchPC)});
      checkOutput("PredNextPC", PredNextPC, expPredNext(FetchPC));
      checkOutput("Mispredict", {31'd0, Mispredict}, {31'd0, expMisp()});
      if (expMisp()) checkOutput("CorrectPC", CorrectPC, expCorrect());
      checkOutput("BranchCount", {16'd0, BranchCount}, mBC);
      checkOutput("MissCount", {16'd0, MissCount}, mMC);
    end
  end

  task automatic tick();
    @(posedge Clk);
    modelUpdate();
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] fetch, input logic valid, input logic [31:0] pc,
                               input logic [5:0] ctl, input logic taken, input logic [31:0] tgt,
                               input logic predT, input logic [31:0] predNext);
    FetchPC = fetch; ResValid = valid; ResPC = pc; ResControl = ctl; ResTaken = taken;
    ResTarget = tgt; ResPredTaken = predT; ResPredNextPC = predNext;
    #1;
  endtask

  logic [31:0] pcPool [8];
  logic [31:0] tgtPool [4];
  logic [5:0]  ctlPool [8];

  initial begin
    pcPool  = '{32'h40, 32'h440, 32'h80, 32'h840, 32'hC0, 32'h4C, 32'hFFFFFFFC, 32'h1040};
    tgtPool = '{32'h100, 32'h200, 32'h300, 32'h44};
    ctlPool = '{6'd18, 6'd19, 6'd23, 6'd24, 6'd25, 6'd0, 6'd7, 6'd40};

    Rst = 1'b0;
    applyStimulus(32'h40, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    Rst = 1'b1;
    checkEn = 1;

    applyStimulus(32'h40, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst PredTaken", {31'd0, PredTaken}, 32'd0);
    checkOutput("rst PredNextPC", PredNextPC, 32'h44);
    checkOutput("rst BranchCount", {16'd0, BranchCount}, 32'd0);
    checkOutput("rst MissCount", {16'd0, MissCount}, 32'd0);
    tick();

    applyStimulus(32'h40, 1, 32'h40, 6'd18, 1, 32'h100, 0, 32'h44);
    checkOutput("beq1 Mispredict", {31'd0, Mispredict}, 32'd1);
    checkOutput("beq1 CorrectPC", CorrectPC, 32'h100);
    checkOutput("same-cycle PredTaken", {31'd0, PredTaken}, 32'd0);
    tick();

    applyStimulus(32'h40, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alloc PredTaken", {31'd0, PredTaken}, 32'd1);
    checkOutput("alloc PredNextPC", PredNextPC, 32'h100);
    checkOutput("alloc MissCount", {16'd0, MissCount}, 32'd1);
    tick();

    applyStimulus(32'h40, 1, 32'h40, 6'd18, 0, 32'h100, 1, 32'h100);
    checkOutput("nt1 Mispredict", {31'd0, Mispredict}, 32'd1);
    checkOutput("nt1 CorrectPC", CorrectPC, 32'h44);
    tick();
    applyStimulus(32'h40, 1, 32'h40, 6'd18, 0, 32'h100, 0, 32'h44);
    checkOutput("nt2 Mispredict", {31'd0, Mispredict}, 32'd0);
    tick();
    applyStimulus(32'h40, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ctr0 PredTaken", {31'd0, PredTaken}, 32'd0);

    applyStimulus(32'h40, 1, 32'h40, 6'd18, 1, 32'h100, 0, 32'h44);  tick();
    applyStimulus(32'h40, 1, 32'h40, 6'd18, 1, 32'h100, 0, 32'h44);  tick();
    applyStimulus(32'h40, 1, 32'h40, 6'd18, 1, 32'h100, 1, 32'h100); tick();
    applyStimulus(32'h40, 1, 32'h40, 6'd18, 1, 32'h100, 1, 32'h100); tick();
    applyStimulus(32'h40, 1, 32'h40, 6'd18, 0, 32'h100, 1, 32'h100); tick();
    applyStimulus(32'h40, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat3 PredTaken", {31'd0, PredTaken}, 32'd1);
    checkOutput("sat3 MissCount", {16'd0, MissCount}, 32'd5);
    checkOutput("sat3 BranchCount", {16'd0, BranchCount}, 32'd8);

    applyStimulus(32'h440, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alias PredTaken", {31'd0, PredTaken}, 32'd0);
    checkOutput("alias PredNextPC", PredNextPC, 32'h444);

    applyStimulus(32'h80, 1, 32'h80, 6'd24, 1, 32'h200, 0, 32'h84);  tick();
    applyStimulus(32'h80, 1, 32'h80, 6'd24, 1, 32'h300, 1, 32'h200);
    checkOutput("jr Mispredict", {31'd0, Mispredict}, 32'd1);
    checkOutput("jr CorrectPC", CorrectPC, 32'h300);
    tick();
    applyStimulus(32'h80, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("jr PredNextPC", PredNextPC, 32'h300);

    applyStimulus(32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap PredNextPC", PredNextPC, 32'h0);

    Rst = 1'b0;
    applyStimulus(32'hC0, 1, 32'hC0, 6'd18, 1, 32'h500, 0, 32'hC4);
    tick();
    Rst = 1'b1;
    applyStimulus(32'hC0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midrst PredTaken", {31'd0, PredTaken}, 32'd0);
    checkOutput("midrst BranchCount", {16'd0, BranchCount}, 32'd0);
    checkOutput("midrst MissCount", {16'd0, MissCount}, 32'd0);
    applyStimulus(32'h40, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midrst cleared", {31'd0, PredTaken}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      logic [5:0]  ctl;
      logic        tk;
      logic        pt;
      logic [31:0] pn;
      pc  = pcPool[$urandom_range(7)];
      ctl = ctlPool[$urandom_range(7)];
      tk  = isJmp(ctl) ? 1'b1 : (isCtl(ctl) ? 1'($urandom_range(1)) : 1'b0);
      if ($urandom_range(9) < 7) begin
        pt = expPredTaken(pc); pn = expPredNext(pc);
      end else begin
        pt = 1'($urandom_range(1)); pn = tgtPool[$urandom_range(3)];
      end
      Rst = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
      applyStimulus(pcPool[$urandom_range(7)], ($urandom_range(9) < 8), pc, ctl, tk,
                    tgtPool[$urandom_range(3)], pt, pn);
      tick();
    end

    Rst = 1'b0;
    applyStimulus(32'h40, 0, 0, 0, 0, 0, 0, 0);
    tick();
    Rst = 1'b1;
    applyStimulus(32'h40, 1, 32'h40, 6'd18, 1, 32'h100, 0, 32'h44);
    for (int n = 0; n < 65540; n++) tick();
    applyStimulus(32'h40, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat MissCount", {16'd0, MissCount}, 32'hFFFF);
    checkOutput("sat BranchCount", {16'd0, BranchCount}, 32'hFFFF);

    checkEn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
